// File: rtl/wfg_stim_sine_multi.sv
`timescale 1ns/1ps
// Multi-channel CORDIC sine stimulus: one shared phase accumulator, one time-multiplexed CORDIC.
// Optional phase-reset input ctrl_phase_rst_i is built when WFG_STIM_SINE_MULTI_PHASE_RST_EN is defined.
module wfg_stim_sine_multi #(
  parameter int NUM_CH  = 2,
  parameter int PHASE_W = 16,
  parameter int DATA_W  = 18,
  parameter int ITER    = 16,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ctrl_en_q_i,
`ifdef WFG_STIM_SINE_MULTI_PHASE_RST_EN
  input  logic                       ctrl_phase_rst_i,
`endif
  input  logic [PHASE_W-1:0]         inc_val_q_i,
  input  logic [NUM_CH*PHASE_W-1:0]  phase_ofs_q_i,
  input  logic [NUM_CH*16-1:0]       gain_val_q_i,
  input  logic [NUM_CH*DATA_W-1:0]   offset_val_q_i,
  input  logic                       wfg_axis_tready_i,
  output logic                       wfg_axis_tvalid_o,
  output logic [DATA_W-1:0]          wfg_axis_tdata_o,
  output logic [CH_W-1:0]            wfg_axis_tuser_o
);
  localparam int ZW   = DATA_W + 2;
  localparam int IT_W = $clog2(ITER);
  localparam logic signed [ZW-1:0] K_VAL =
    ZW'((64'd607253 * (64'd1 << (DATA_W - 1)) + 64'd500000) / 64'd1000000);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic signed [DATA_W-1:0] DATA_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // atan(2^-i) for a 2^32 full circle, rescaled with rounding to 2^PHASE_W.
  function automatic longint atan_q32(input int i);
    case (i)
      0:  return 64'd536870912;
      1:  return 64'd316933406;
      2:  return 64'd167458907;
      3:  return 64'd85004756;
      4:  return 64'd42667331;
      5:  return 64'd21354465;
      6:  return 64'd10679838;
      7:  return 64'd5340245;
      8:  return 64'd2670163;
      9:  return 64'd1335087;
      10: return 64'd667544;
      11: return 64'd333772;
      12: return 64'd166886;
      13: return 64'd83443;
      14: return 64'd41722;
      15: return 64'd20861;
      16: return 64'd10430;
      default: return 64'd683565276 >> i;
    endcase
  endfunction

  function automatic longint atan_scaled(input int i);
    longint v;
    v = atan_q32(i);
    if (PHASE_W >= 32) return v;
    return (v + (64'd1 << (31 - PHASE_W))) >> (32 - PHASE_W);
  endfunction

  logic signed [ZW-1:0] atan_tab [1 << IT_W];
  for (genvar g = 0; g < (1 << IT_W); g++) begin : g_atan
    if (g < ITER) begin : g_val
      assign atan_tab[g] = ZW'(atan_scaled(g));
    end else begin : g_pad
      assign atan_tab[g] = '0;
    end
  end

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_SCALE, S_DONE} state_t;
  state_t state;

  logic [PHASE_W-1:0]       acc;
  logic [CH_W-1:0]          ch;
  logic [IT_W-1:0]          iter;
  logic [1:0]               quad;
  logic [14:0]              gain_r;
  logic signed [DATA_W-1:0] offset_r;
  logic signed [ZW-1:0]     x, y, z, x_sh, y_sh;
  logic                     tvalid;
  logic [DATA_W-1:0]        tdata;
  logic [CH_W-1:0]          tuser;

  logic [PHASE_W-1:0] angle;
  logic [15:0]        gain_sel;
  assign angle    = acc + phase_ofs_q_i[32'(ch)*PHASE_W +: PHASE_W];
  assign gain_sel = gain_val_q_i[32'(ch)*16 +: 16];
  assign x_sh     = x >>> iter;
  assign y_sh     = y >>> iter;

`ifdef WFG_STIM_SINE_MULTI_PHASE_RST_EN
  logic pending;
  logic idle_clr, phase_clr;
  assign idle_clr  = ctrl_phase_rst_i;
  assign phase_clr = pending | ctrl_phase_rst_i;

  always_ff @(posedge clk) begin
    if (rst) pending <= 1'b0;
    else if (state == S_DONE && wfg_axis_tready_i && ch == LAST_CH) pending <= 1'b0;
    else if (state != S_IDLE && ctrl_phase_rst_i) pending <= 1'b1;
  end
`else
  logic idle_clr, phase_clr;
  assign idle_clr  = 1'b0;
  assign phase_clr = 1'b0;
`endif

  logic signed [ZW-1:0]     sel;
  logic signed [ZW+15:0]    prod;
  logic signed [DATA_W:0]   p_w, sum_w;
  logic signed [DATA_W-1:0] sat_w;
  logic                     unused_prod;

  always_comb begin
    case (quad)
      2'd0:    sel = y;
      2'd1:    sel = x;
      2'd2:    sel = -y;
      default: sel = -x;
    endcase
    prod  = (ZW+16)'(sel) * (ZW+16)'($signed({1'b0, gain_r}));
    p_w   = prod[DATA_W+15:15];
    sum_w = p_w + (DATA_W+1)'(offset_r);
    sat_w = sum_w[DATA_W-1:0];
    if (sum_w[DATA_W] != sum_w[DATA_W-1]) sat_w = sum_w[DATA_W] ? DATA_MIN : DATA_MAX;
  end
  assign unused_prod = ^{prod[14:0], prod[ZW+15:DATA_W+16]};

  // tvalid rises out of SCALE and holds tdata/tuser until an edge with tready=1;
  // that edge is the transfer and tvalid drops after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      acc      <= '0;
      ch       <= '0;
      iter     <= '0;
      quad     <= '0;
      gain_r   <= '0;
      offset_r <= '0;
      x        <= '0;
      y        <= '0;
      z        <= '0;
      tvalid   <= 1'b0;
      tdata    <= '0;
      tuser    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (idle_clr) acc <= '0;
          if (ctrl_en_q_i) begin
            ch    <= '0;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          quad     <= angle[PHASE_W-1 -: 2];
          z        <= ZW'(angle[PHASE_W-3:0]);
          x        <= K_VAL;
          y        <= '0;
          iter     <= '0;
          gain_r   <= (gain_sel > 16'h7FFF) ? 15'h7FFF : gain_sel[14:0];
          offset_r <= offset_val_q_i[32'(ch)*DATA_W +: DATA_W];
          state    <= S_CALC;
        end
        S_CALC: begin
          if (!z[ZW-1]) begin
            x <= x - y_sh;
            y <= y + x_sh;
            z <= z - atan_tab[iter];
          end else begin
            x <= x + y_sh;
            y <= y - x_sh;
            z <= z + atan_tab[iter];
          end
          iter <= iter + IT_W'(1);
          if (iter == IT_W'(ITER - 1)) state <= S_SCALE;
        end
        S_SCALE: begin
          tdata  <= sat_w;
          tuser  <= ch;
          tvalid <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: begin
          if (wfg_axis_tready_i) begin
            tvalid <= 1'b0;
            if (ch != LAST_CH) begin
              ch    <= ch + CH_W'(1);
              state <= S_LOAD;
            end else begin
              ch    <= '0;
              acc   <= phase_clr ? '0 : acc + inc_val_q_i;
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign wfg_axis_tvalid_o = tvalid;
  assign wfg_axis_tdata_o  = tdata;
  assign wfg_axis_tuser_o  = tuser;
endmodule

// File: tb/tb_wfg_stim_sine_multi.sv
`timescale 1ns/1ps
// Directed bench for wfg_stim_sine_multi (2 channels): reset, quadrant sweep, saturation,
// gain clamp, backpressure, enable drop and synchronous reset during CALC.
module tb_wfg_stim_sine_multi;
  localparam int NUM_CH  = 2;
  localparam int PHASE_W = 16;
  localparam int DATA_W  = 18;
  localparam int ITER    = 16;
  localparam int CH_W    = 1;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      en;
  logic [PHASE_W-1:0]        inc;
  logic [NUM_CH*PHASE_W-1:0] ofs;
  logic [NUM_CH*16-1:0]      gain;
  logic [NUM_CH*DATA_W-1:0]  offset;
  logic                      tready;
  logic                      tvalid;
  logic [DATA_W-1:0]         tdata;
  logic [CH_W-1:0]           tuser;
  logic signed [31:0]        data_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wfg_stim_sine_multi #(
    .NUM_CH(NUM_CH), .PHASE_W(PHASE_W), .DATA_W(DATA_W), .ITER(ITER)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ctrl_en_q_i(en),
`ifdef WFG_STIM_SINE_MULTI_PHASE_RST_EN
    .ctrl_phase_rst_i(1'b0),
`endif
    .inc_val_q_i(inc),
    .phase_ofs_q_i(ofs),
    .gain_val_q_i(gain),
    .offset_val_q_i(offset),
    .wfg_axis_tready_i(tready),
    .wfg_axis_tvalid_o(tvalid),
    .wfg_axis_tdata_o(tdata),
    .wfg_axis_tuser_o(tuser)
  );

  assign data_s = 32'($signed(tdata));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic signed [31:0] obs,
                          input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input logic signed [31:0] obs,
                            input int exp, input int tol);
    checks++;
    assert (((obs >= exp - tol) && (obs <= exp + tol)) === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
    end
  endtask

  // Waits (bounded) for the next tvalid, then checks edge count, channel tag and sample.
  task automatic get_sample(input string tag, input int exp_gap, input int exp_user,
                            input int exp_data, input int tol);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (tvalid !== 1'b1 && n < 100);
    check_eq({tag, "_valid"}, 32'(tvalid), 1);
    check_eq({tag, "_gap"}, n, exp_gap);
    check_eq({tag, "_user"}, 32'(tuser), exp_user);
    check_near({tag, "_data"}, data_s, exp_data, tol);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0 [4] = '{0, 131068, 0, -131068};
    int e1 [4] = '{131068, 0, -131068, 0};
    logic [19:0] hold_exp;
    int hi;

    rst    = 1'b1;
    en     = 1'b0;
    inc    = 16'h4000;
    ofs    = {16'h4000, 16'h0000};
    gain   = {16'h7FFF, 16'h7FFF};
    offset = '0;
    tready = 1'b1;
    repeat (3) tick();
    check_eq("rst_valid", 32'(tvalid), 0);
    check_eq("rst_data", data_s, 0);
    check_eq("rst_user", 32'(tuser), 0);

    // Enable: 1 edge into LOAD plus ITER+2 = 18 cycles to tvalid -> 19 edges.
    rst = 1'b0;
    en  = 1'b1;
    for (int f = 0; f < 4; f++) begin
      get_sample($sformatf("f%0d_c0", f), (f == 0) ? 19 : 20, 0, e0[f], 8);
      get_sample($sformatf("f%0d_c1", f), 19, 1, e1[f], 8);
    end

    // acc wrapped 0xC000 -> 0x0000; ch1 (angle 0x4000) saturates high.
    get_sample("f4_c0", 20, 0, 0, 8);
    offset[DATA_W +: DATA_W] = 18'h1FFFF;
    get_sample("sat_hi", 19, 1, 131071, 0);

    tready   = 1'b0;
    hold_exp = {1'b1, 1'b1, 18'h1FFFF};
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq($sformatf("bp_hold%0d", i), 32'({tvalid, tuser, tdata}), 32'(hold_exp));
    end
    gain[0 +: 16]            = 16'hFFFF;
    ofs[PHASE_W +: PHASE_W]  = 16'h8000;
    offset[DATA_W +: DATA_W] = 18'h20000;
    tready = 1'b1;

    // acc advanced exactly once to 0x4000 despite backpressure; 0xFFFF gain clamps to 0x7FFF.
    get_sample("gain_clamp", 20, 0, 131068, 2);
    get_sample("sat_lo", 19, 1, -131072, 0);

    gain[0 +: 16]            = 16'h4000;
    ofs[0 +: PHASE_W]        = 16'hC000;
    offset[DATA_W +: DATA_W] = '0;
    get_sample("gain_half", 20, 0, 65534, 8);
    en = 1'b0;
    get_sample("en_drop_c1", 19, 1, 0, 8);
    hi = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tvalid !== 1'b0) hi++;
    end
    check_eq("idle_no_valid", hi, 0);

    // Reset during CALC, then restart from acc=0, ch0.
    ofs[0 +: PHASE_W] = 16'h4000;
    gain[0 +: 16]     = 16'h7FFF;
    en = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check_eq("calc_rst_valid", 32'(tvalid), 0);
    check_eq("calc_rst_data", data_s, 0);
    check_eq("calc_rst_user", 32'(tuser), 0);
    rst = 1'b0;
    get_sample("restart_c0", 19, 0, 131068, 8);
    get_sample("restart_c1", 19, 1, 0, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
